// File: rtl/display_mode_scheduler.sv
// display_mode_scheduler
//   Frame-synchronous configuration scheduler for the Sobel / posterize filter.
//   Button presses and an auto-cycle frame counter produce a requested display
//   mode. That mode is committed to the filter controls only on a vsync rising
//   edge while the pipeline is idle, so no frame is rendered with mixed settings.
//
// Ports
//   i_pclk          pixel clock, all logic on the rising edge
//   i_srst_n        synchronous active-low reset
//   i_sw_n          raw pushbutton, active low, asynchronous
//   i_vsync         camera frame sync, active high, asynchronous
//   i_pipe_idle     filter pipeline empty (pclk-synchronous)
//   o_posterize_en  posterize stage enable (0 = posterize active)
//   o_display_sel   display select to the filter mux
//   o_auto_mode     auto-cycle active
//   o_cfg_update    one-cycle pulse when a new configuration is committed
module display_mode_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEBOUNCE_WIDTH  = 16,
  parameter int unsigned AUTO_FRAMES     = 60,
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic       i_pclk,
  input  logic       i_srst_n,
  input  logic       i_sw_n,
  input  logic       i_vsync,
  input  logic       i_pipe_idle,
  output logic       o_posterize_en,
  output logic [1:0] o_display_sel,
  output logic       o_auto_mode,
  output logic       o_cfg_update
);

  typedef enum logic [1:0] {S_RUN, S_PEND, S_APPLY} state_t;

  localparam logic [DEBOUNCE_WIDTH-1:0]  DB_LAST    = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_LAST = FRAME_CNT_WIDTH'(AUTO_FRAMES - 1);

  logic sw_s1, sw_s2;
  logic vs_s1, vs_s2, vs_d, vs_rise;
  logic db_level, db_d, press;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt;

  logic [1:0]                 req_mode, act_mode;
  logic                       auto_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  state_t     state_q, state_d;
  logic       commit;
  logic       post_d;
  logic [1:0] sel_d;
  logic       post_q, upd_q;
  logic [1:0] sel_q;

  // Synchronizers and registered vsync rising-edge pulse
  always_ff @(posedge i_pclk) begin
    if (!i_srst_n) begin
      sw_s1   <= 1'b1;
      sw_s2   <= 1'b1;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_d    <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      sw_s1   <= i_sw_n;
      sw_s2   <= sw_s1;
      vs_s1   <= i_vsync;
      vs_s2   <= vs_s1;
      vs_d    <= vs_s2;
      vs_rise <= vs_s2 & ~vs_d;
    end
  end

  // Debounce: count consecutive samples that differ from the accepted level;
  // a sample matching the accepted level restarts the count.
  always_ff @(posedge i_pclk) begin
    if (!i_srst_n) begin
      db_level <= 1'b1;
      db_d     <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      db_d  <= db_level;
      press <= db_d & ~db_level;
      if (sw_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sw_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Requested mode, auto flag and frame counter; a press overrides an
  // auto-advance arriving in the same cycle.
  always_ff @(posedge i_pclk) begin
    if (!i_srst_n) begin
      req_mode  <= 2'd0;
      auto_q    <= 1'b0;
      frame_cnt <= '0;
    end else if (press) begin
      if (auto_q) begin
        auto_q    <= 1'b0;
        req_mode  <= 2'd0;
        frame_cnt <= '0;
      end else if (req_mode == 2'd3) begin
        auto_q    <= 1'b1;
        req_mode  <= 2'd0;
        frame_cnt <= '0;
      end else begin
        req_mode <= req_mode + 2'd1;
      end
    end else if (auto_q && vs_rise) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        req_mode  <= req_mode + 2'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Commit FSM: state register
  always_ff @(posedge i_pclk) begin
    if (!i_srst_n) state_q <= S_RUN;
    else           state_q <= state_d;
  end

  // Commit FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (req_mode != act_mode) state_d = S_PEND;
      S_PEND: begin
        if (req_mode == act_mode)          state_d = S_RUN;
        else if (vs_rise && i_pipe_idle)   state_d = S_APPLY;
      end
      S_APPLY: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Commit FSM: outputs. The filter controls are loaded on the edge that
  // enters S_APPLY so the new values appear exactly in the S_APPLY cycle.
  always_comb begin
    commit = (state_q == S_PEND) && (state_d == S_APPLY);
    post_d = 1'b1;
    sel_d  = 2'b00;
    case (req_mode)
      2'd1:    sel_d  = 2'b01;
      2'd2:    sel_d  = 2'b10;
      2'd3:    post_d = 1'b0;
      default: sel_d  = 2'b00;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!i_srst_n) begin
      act_mode <= 2'd0;
      post_q   <= 1'b1;
      sel_q    <= 2'b00;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= commit;
      if (commit) begin
        act_mode <= req_mode;
        post_q   <= post_d;
        sel_q    <= sel_d;
      end
    end
  end

  assign o_posterize_en = post_q;
  assign o_display_sel  = sel_q;
  assign o_auto_mode    = auto_q;
  assign o_cfg_update   = upd_q;

endmodule
